layer_overlap_scanner: RTL and testbench

Raster-scan collision engine for the frame layers. It compares one reference layer (the ship) against `CHANNELS` object layers (asteroids) over a `WIDTH`×`HEIGHT` pixel grid and reports which channels overlap the reference. It also reports the first overlapping pixel and the count of overlapping pixels. It replaces wide flat-vector layer inputs with a pixel-address read port into the layer stores. It runs once per frame on a `start` pulse and signals completion with `done`.

---
 rtl/layer_overlap_scanner_if.sv | 33 +++
 rtl/layer_overlap_scanner.sv | 148 ++++++++++++++
 tb/tb_layer_overlap_scanner.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/layer_overlap_scanner_if.sv
// Bus bundle for layer_overlap_scanner: control handshake, layer-store read port,
// returned pixel data and the per-frame collision results.
interface layer_overlap_scanner_if #(
  parameter int CHANNELS = 16,
  parameter int XW       = 8,
  parameter int YW       = 7,
  parameter int CW       = 15
);
  logic                start;
  logic [CHANNELS-1:0] chan_en;
  logic                rd_en;
  logic [XW-1:0]       rd_x;
  logic [YW-1:0]       rd_y;
  logic                ref_bit;
  logic [CHANNELS-1:0] obj_bits;
  logic                busy;
  logic                done;
  logic                hit_any;
  logic [CHANNELS-1:0] hit_mask;
  logic [XW-1:0]       first_x;
  logic [YW-1:0]       first_y;
  logic [CW-1:0]       hit_count;

  modport master (
    output start, chan_en, ref_bit, obj_bits,
    input  rd_en, rd_x, rd_y, busy, done, hit_any, hit_mask, first_x, first_y, hit_count
  );

  modport slave (
    input  start, chan_en, ref_bit, obj_bits,
    output rd_en, rd_x, rd_y, busy, done, hit_any, hit_mask, first_x, first_y, hit_count
  );
endinterface

// File: rtl/layer_overlap_scanner.sv
// Raster-scan collision engine: reads every pixel of the reference and object layers
// once per frame and accumulates per-channel overlap flags, first hit and hit count.
module layer_overlap_scanner #(
  parameter int WIDTH    = 160,
  parameter int HEIGHT   = 120,
  parameter int CHANNELS = 16,
  parameter int XW       = 8,
  parameter int YW       = 7,
  parameter int CW       = 15
) (
  input  logic                  clock,
  input  logic                  resetn,
  layer_overlap_scanner_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t              state_q, state_d;
  logic [XW-1:0]       x_q, x_d;
  logic [YW-1:0]       y_q, y_d;
  logic                rd_en_q, rd_en_d;
  logic                vld_p1_q, vld_p1_d;
  logic [XW-1:0]       x_p1_q, x_p1_d;
  logic [YW-1:0]       y_p1_q, y_p1_d;
  logic [CHANNELS-1:0] en_q, en_d;
  logic [CHANNELS-1:0] hit_mask_q, hit_mask_d;
  logic                hit_any_q, hit_any_d;
  logic [XW-1:0]       first_x_q, first_x_d;
  logic [YW-1:0]       first_y_q, first_y_d;
  logic [CW-1:0]       hit_count_q, hit_count_d;
  logic [CHANNELS-1:0] hit_vec;
  logic                last_addr, last_addr_p1;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  assign hit_vec      = bus.obj_bits & en_q & {CHANNELS{bus.ref_bit}};
  assign last_addr    = (x_q == XW'(WIDTH - 1)) && (y_q == YW'(HEIGHT - 1));
  assign last_addr_p1 = (x_p1_q == XW'(WIDTH - 1)) && (y_p1_q == YW'(HEIGHT - 1));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      rd_en_q     <= 1'b0;
      vld_p1_q    <= 1'b0;
      x_p1_q      <= '0;
      y_p1_q      <= '0;
      en_q        <= '0;
      hit_mask_q  <= '0;
      hit_any_q   <= 1'b0;
      first_x_q   <= '0;
      first_y_q   <= '0;
      hit_count_q <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      rd_en_q     <= rd_en_d;
      vld_p1_q    <= vld_p1_d;
      x_p1_q      <= x_p1_d;
      y_p1_q      <= y_p1_d;
      en_q        <= en_d;
      hit_mask_q  <= hit_mask_d;
      hit_any_q   <= hit_any_d;
      first_x_q   <= first_x_d;
      first_y_q   <= first_y_d;
      hit_count_q <= hit_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    rd_en_d     = rd_en_q;
    en_d        = en_q;
    hit_mask_d  = hit_mask_q;
    hit_any_d   = hit_any_q;
    first_x_d   = first_x_q;
    first_y_d   = first_y_q;
    hit_count_d = hit_count_q;
    // address stage -> compare stage: data returns one cycle after its address
    vld_p1_d    = rd_en_q;
    x_p1_d      = x_q;
    y_p1_d      = y_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d     = SCAN;
          x_d         = '0;
          y_d         = '0;
          rd_en_d     = 1'b1;
          en_d        = bus.chan_en;
          hit_mask_d  = '0;
          hit_any_d   = 1'b0;
          first_x_d   = '0;
          first_y_d   = '0;
          hit_count_d = '0;
        end
      end
      SCAN: begin
        if (rd_en_q) begin
          if (last_addr) begin
            x_d     = '0;
            y_d     = '0;
            rd_en_d = 1'b0;
          end else if (x_q == XW'(WIDTH - 1)) begin
            x_d = '0;
            y_d = y_q + YW'(1);
          end else begin
            x_d = x_q + XW'(1);
          end
        end
        // compare stage: fold the returned pixel into the frame results
        if (vld_p1_q) begin
          hit_mask_d = hit_mask_q | hit_vec;
          if (|hit_vec) begin
            if (!hit_any_q) begin
              first_x_d = x_p1_q;
              first_y_d = y_p1_q;
            end
            hit_any_d   = 1'b1;
            hit_count_d = sat_inc(hit_count_q);
          end
          if (last_addr_p1) state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.rd_en     = rd_en_q;
  assign bus.rd_x      = x_q;
  assign bus.rd_y      = y_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.hit_any   = hit_any_q;
  assign bus.hit_mask  = hit_mask_q;
  assign bus.first_x   = first_x_q;
  assign bus.first_y   = first_y_q;
  assign bus.hit_count = hit_count_q;

endmodule

// File: tb/tb_layer_overlap_scanner.sv
// Scoreboard bench for layer_overlap_scanner on a 4x3 frame with 4 channels and a
// 3-bit hit counter; expected results come from a raster-order reference loop.
module tb_layer_overlap_scanner;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int C  = 4;
  localparam int N  = W * H;
  localparam int CMAX = 7;

  typedef struct {
    int start_cyc;
    int any;
    int mask;
    int fx;
    int fy;
    int cnt;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   total;
  int   bad;
  int   n_mon;
  exp_t sb[$];
  logic [C-1:0] obj_mem[N];
  logic         ref_mem[N];

  layer_overlap_scanner_if #(.CHANNELS(C), .XW(2), .YW(2), .CW(3)) bus ();

  layer_overlap_scanner #(
    .WIDTH(W), .HEIGHT(H), .CHANNELS(C), .XW(2), .YW(2), .CW(3)
  ) dut (
    .clock (clk),
    .resetn(rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // layer stores: data one cycle after the read strobe, garbage otherwise
  always @(posedge clk) begin
    if (bus.rd_en) begin
      bus.ref_bit  <= ref_mem[int'(bus.rd_y) * W + int'(bus.rd_x)];
      bus.obj_bits <= obj_mem[int'(bus.rd_y) * W + int'(bus.rd_x)];
    end else begin
      bus.ref_bit  <= 1'($urandom);
      bus.obj_bits <= C'($urandom);
    end
  end

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t model(input int en, input int st);
    exp_t e;
    e.start_cyc = st;
    e.any = 0; e.mask = 0; e.fx = 0; e.fy = 0; e.cnt = 0;
    for (int n = 0; n < N; n++) begin
      int v;
      v = ref_mem[n] ? (int'(obj_mem[n]) & en) : 0;
      e.mask |= v;
      if (v != 0) begin
        if (e.any == 0) begin
          e.fx = n % W;
          e.fy = n / W;
        end
        e.any = 1;
        if (e.cnt < CMAX) e.cnt++;
      end
    end
    return e;
  endfunction

  // monitor: address sequence and results at done
  always @(negedge clk) begin
    if (rst_n) begin
      if (sb.size() > 0) begin
        n_mon = cyc - sb[0].start_cyc;
        if (n_mon >= 0 && n_mon < N) begin
          chk("rd_en_active", int'(bus.rd_en), 1);
          chk("rd_x", int'(bus.rd_x), n_mon % W);
          chk("rd_y", int'(bus.rd_y), n_mon / W);
        end else if (n_mon == N) begin
          chk("rd_en_drop", int'(bus.rd_en), 0);
        end
      end
      if (bus.done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("done_latency", cyc - e.start_cyc, N + 1);
          chk("busy_at_done", int'(bus.busy), 1);
          chk("hit_any", int'(bus.hit_any), e.any);
          chk("hit_mask", int'(bus.hit_mask), e.mask);
          chk("first_x", int'(bus.first_x), e.fx);
          chk("first_y", int'(bus.first_y), e.fy);
          chk("hit_count", int'(bus.hit_count), e.cnt);
        end
      end
    end
  end

  task automatic fill(input logic r, input logic [C-1:0] o);
    for (int n = 0; n < N; n++) begin
      ref_mem[n] = r;
      obj_mem[n] = o;
    end
  endtask

  task automatic do_start(input logic [C-1:0] en, output int st);
    @(negedge clk); #1;
    st = cyc + 1;
    sb.push_back(model(int'(en), st));
    bus.chan_en = en;
    bus.start   = 1'b1;
    @(negedge clk); #1;
    bus.start   = 1'b0;
    bus.chan_en = C'($urandom);
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 40) begin
      @(negedge clk); #1;
      k++;
    end
    if (sb.size() != 0) begin
      chk("scan_timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clk); #1;
    chk("busy_after_done", int'(bus.busy), 0);
  endtask

  task automatic scan(input logic [C-1:0] en);
    int st;
    do_start(en, st);
    wait_done();
  endtask

  task automatic pulse_at(input int edge_cyc, input logic [C-1:0] en);
    while (cyc < edge_cyc - 1) begin
      @(negedge clk); #1;
    end
    bus.chan_en = en;
    bus.start   = 1'b1;
    @(negedge clk); #1;
    bus.start   = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_en"}, int'(bus.rd_en), 0);
    chk({tag, "_rd_xy"}, int'({bus.rd_x, bus.rd_y}), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
    chk({tag, "_hit_any"}, int'(bus.hit_any), 0);
    chk({tag, "_hit_mask"}, int'(bus.hit_mask), 0);
    chk({tag, "_first"}, int'({bus.first_x, bus.first_y}), 0);
    chk({tag, "_hit_count"}, int'(bus.hit_count), 0);
  endtask

  initial begin
    int st;
    cyc = 0; total = 0; bad = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.chan_en = '0;
    fill(1'b0, '0);
    repeat (3) @(negedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;

    // no overlap
    fill(1'b1, '0);
    scan(4'hF);

    // single pixel at the last address, then at the first
    fill(1'b0, '0);
    ref_mem[11] = 1'b1; obj_mem[11] = 4'b0100;
    scan(4'hF);
    fill(1'b0, '0);
    ref_mem[0] = 1'b1; obj_mem[0] = 4'b0100;
    scan(4'hF);

    // multi-channel
    fill(1'b0, '0);
    ref_mem[1] = 1'b1; ref_mem[6] = 1'b1;
    obj_mem[6] = 4'b0011; obj_mem[1] = 4'b0010;
    scan(4'hF);

    // masking with counter saturation, and all channels disabled
    fill(1'b1, 4'hF);
    scan(4'b1000);
    scan(4'b0000);

    // stray starts during the scan are ignored; restart one edge after done falls
    fill(1'b1, 4'b0110);
    ref_mem[3] = 1'b0;
    do_start(4'hF, st);
    pulse_at(st + 5, 4'h0);
    pulse_at(st + 13, 4'h0);
    wait_done();
    fill(1'b0, '0);
    ref_mem[9] = 1'b1; obj_mem[9] = 4'b0001;
    do_start(4'hF, st);
    chk("restart_edge", st, cyc);
    wait_done();

    // reset mid-scan at address (2,1) after a hit at (1,0)
    fill(1'b0, '0);
    ref_mem[1] = 1'b1; obj_mem[1] = 4'b0010;
    do_start(4'hF, st);
    while (cyc < st + 6) begin
      @(negedge clk); #1;
    end
    chk("pre_reset_hit_any", int'(bus.hit_any), 1);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk_all_zero("midreset");
    @(negedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      chk("no_done_after_reset", int'(bus.done), 0);
    end
    fill(1'b0, '0);
    ref_mem[5] = 1'b1; obj_mem[5] = 4'b1001;
    scan(4'hF);

    // randomized frames
    for (int t = 0; t < 8; t++) begin
      for (int n = 0; n < N; n++) begin
        ref_mem[n] = ($urandom_range(0, 2) != 0);
        obj_mem[n] = C'($urandom) & C'($urandom);
      end
      scan(C'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=0", sb.size());
    $fatal(1, "timeout");
  end
endmodule
